uart_cmd_parser: RTL and testbench
==================================

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter CLK_PER, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAND_RATE, default 9600, UART baud rate.
REQ-003 Parameter GAP_BYTES, default 4, inter-byte timeout in byte times (1 byte time = 10 bit times).
REQ-004 clk_i  in  1  single system clock, rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 rd_data  in  8  received byte from the UART receiver.
REQ-007 rd_data_valid  in  1  one-cycle strobe qualifying rd_data.
REQ-008 cmd_wr  out  1  one-cycle write-command strobe.
REQ-009 cmd_rd  out  1  one-cycle read-command strobe.
REQ-010 cmd_addr  out  8  command address, held until next command.
REQ-011 cmd_wdata  out  8  command data, held until next command.
REQ-012 err_chk / err_cmd / err_tmo  out  1 each  one-cycle error strobes: checksum, unknown CMD, timeout.
REQ-013 err_cnt  out  8  saturating total error count.

Function
REQ-014 Frame format SHALL be 5 bytes: SOF=0xA5, CMD, ADDR, DATA, CHK; CHK = CMD ^ ADDR ^ DATA.
REQ-015 FSM states SHALL be IDLE, S_CMD, S_ADDR, S_DATA, S_CHK; each advances on rd_data_valid only.
REQ-016 IDLE: byte 0xA5 -> S_CMD; any other byte discarded, no error.
REQ-017 S_CMD/S_ADDR/S_DATA: capture byte into internal register, advance; 0xA5 inside a frame is data, no resync.
REQ-018 S_CHK: on byte, return to IDLE and evaluate frame in the same clock edge.
REQ-019 Checksum match, CMD=0x01: cmd_wr=1 on the cycle after the CHK strobe; cmd_addr/cmd_wdata updated on that same edge.
REQ-020 Checksum match, CMD=0x02: cmd_rd=1 on the cycle after CHK; cmd_addr updated, cmd_wdata unchanged.
REQ-021 Checksum mismatch: err_chk pulse only, no command, cmd_addr/cmd_wdata unchanged; checksum error takes priority over CMD error.
REQ-022 Checksum match with CMD not 0x01/0x02: err_cmd pulse only, no command.
REQ-023 Gap timer SHALL count clocks while state != IDLE, clear on every rd_data_valid, clear in IDLE.
REQ-024 Timer limit = GAP_BYTES*10*(CLK_PER/BAND_RATE) clocks; reaching limit -> state IDLE, err_tmo pulse, partial frame dropped.
REQ-025 rd_data_valid on the same cycle the limit is reached: byte wins, timer clears, no timeout.
REQ-026 Each error strobe increments err_cnt by 1; saturates at 255, no wrap.
REQ-027 At most one strobe among cmd_wr, cmd_rd, err_* SHALL be high in any cycle.
REQ-028 Back-to-back frames with zero idle gap SHALL be accepted; a frame's SOF may arrive the cycle after the previous CHK.
REQ-029 Timer width SHALL hold the limit for all legal parameters; minimum 24 bits.

Reset
REQ-030 While rst_n=0: state IDLE, timer 0, all strobes 0, cmd_addr=0, cmd_wdata=0, err_cnt=0, internal captures 0.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame; no strobe after release until a new complete frame.
REQ-032 Outputs SHALL be registered; no combinational path from rd_data to any output.

Structure
REQ-033 Shared package uart_pkg SHALL hold SOF (0xA5), CMD_WR (0x01), CMD_RD (0x02), FSM state encoding, and frame length.
REQ-034 Gap timer SHALL be a sub-module uart_gap_timer (inputs clk_i, rst_n, run, clr; output expired); all else inline.

Verification
REQ-035 Frame A5 01 10 3C 2D -> one cmd_wr pulse, cmd_addr=0x10, cmd_wdata=0x3C, err_cnt=0.
REQ-036 Frame A5 02 22 00 20 -> one cmd_rd pulse, cmd_addr=0x22, cmd_wdata unchanged.
REQ-037 Frame A5 01 10 3C 00 -> err_chk pulse, no cmd strobe, err_cnt=1; A5 07 00 00 07 -> err_cmd, err_cnt=2.
REQ-038 A5 01 then silence > limit -> err_tmo exactly once, state IDLE; following valid frame decodes correctly.
REQ-039 Bytes 00 FF 12 then A5 01 AA 55 FE -> garbage ignored silently, cmd_wr with addr 0xAA, data 0x55.
REQ-040 256 bad-checksum frames -> err_cnt stays 255; rst_n low mid-frame then full valid frame -> single correct strobe.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and types for the UART command parser.
//   SOF / CMD_WR / CMD_RD : frame start marker and the two recognised opcodes
//   FRAME_LEN             : bytes per frame (SOF, CMD, ADDR, DATA, CHK)
//   state_t               : parser FSM encoding
//   frame_t               : captured frame body awaiting its checksum
//   gap_limit/tmr_width   : inter-byte timeout sizing helpers
package uart_pkg;

    localparam logic [7:0]  SOF           = 8'hA5;
    localparam logic [7:0]  CMD_WR        = 8'h01;
    localparam logic [7:0]  CMD_RD        = 8'h02;
    localparam int unsigned FRAME_LEN     = 5;
    localparam int unsigned BITS_PER_BYTE = 10;
    localparam int unsigned MIN_TMR_W     = 24;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_CMD  = 3'd1,
        S_ADDR = 3'd2,
        S_DATA = 3'd3,
        S_CHK  = 3'd4
    } state_t;

    typedef struct packed {
        logic [7:0] cmd;
        logic [7:0] addr;
        logic [7:0] data;
    } frame_t;

    // Gap limit in clocks; never zero so the timer always has a reachable target.
    function automatic int unsigned gap_limit(input int unsigned clk_per,
                                              input int unsigned baud,
                                              input int unsigned gap_bytes);
        int unsigned lim;
        lim = gap_bytes * BITS_PER_BYTE * (clk_per / baud);
        return (lim == 0) ? 1 : lim;
    endfunction

    // Counter width able to hold the limit, with a floor of MIN_TMR_W bits.
    function automatic int unsigned tmr_width(input int unsigned limit);
        int unsigned w;
        w = $clog2(64'(limit) + 64'd1);
        return (w < MIN_TMR_W) ? MIN_TMR_W : w;
    endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer.
//   clk_i, rst_n : clock, async active-low reset
//   run          : count while high (parser is mid-frame)
//   clr          : synchronous clear (byte received)
//   expired      : registered one-cycle pulse on the clock the count reaches LIMIT
module uart_gap_timer #(
    parameter int unsigned LIMIT = 1,
    parameter int unsigned CNT_W = 24
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic expired
);

    logic [CNT_W-1:0] cnt_q;

    // Count saturates at LIMIT so expired can only pulse once per silence.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            expired <= 1'b0;
        end else if (clr || !run) begin
            cnt_q   <= '0;
            expired <= 1'b0;
        end else begin
            if (cnt_q != CNT_W'(LIMIT)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            expired <= (cnt_q == CNT_W'(LIMIT - 1));
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// UART command frame parser: SOF(A5) CMD ADDR DATA CHK, CHK = CMD^ADDR^DATA.
//   clk_i, rst_n           : clock, async active-low reset
//   rd_data, rd_data_valid : received byte and its one-cycle qualifier
//   cmd_wr, cmd_rd         : one-cycle command strobes (cycle after CHK byte)
//   cmd_addr, cmd_wdata    : command fields, held until the next command
//   err_chk/err_cmd/err_tmo: one-cycle error strobes
//   err_cnt                : saturating error count
module uart_cmd_parser
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER   = 50_000_000,
    parameter int unsigned BAND_RATE = 9600,
    parameter int unsigned GAP_BYTES = 4
) (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic [7:0] rd_data,
    input  logic       rd_data_valid,
    output logic       cmd_wr,
    output logic       cmd_rd,
    output logic [7:0] cmd_addr,
    output logic [7:0] cmd_wdata,
    output logic       err_chk,
    output logic       err_cmd,
    output logic       err_tmo,
    output logic [7:0] err_cnt
);

    localparam int unsigned GAP_LIMIT = gap_limit(CLK_PER, BAND_RATE, GAP_BYTES);
    localparam int unsigned TMR_W     = tmr_width(GAP_LIMIT);

    state_t     state_q, state_d;
    frame_t     frame_q, frame_d;
    logic [7:0] addr_d, wdata_d, err_cnt_d;
    logic       wr_d, rd_d, chk_err_d, cmd_err_d, tmo_err_d;
    logic       tmr_expired;

    uart_gap_timer #(
        .LIMIT (GAP_LIMIT),
        .CNT_W (TMR_W)
    ) u_gap_timer (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .run     (state_q != IDLE),
        .clr     (rd_data_valid),
        .expired (tmr_expired)
    );

    // State, captures and all outputs are registered here.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            cmd_wr    <= 1'b0;
            cmd_rd    <= 1'b0;
            cmd_addr  <= 8'h00;
            cmd_wdata <= 8'h00;
            err_chk   <= 1'b0;
            err_cmd   <= 1'b0;
            err_tmo   <= 1'b0;
            err_cnt   <= 8'h00;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            cmd_wr    <= wr_d;
            cmd_rd    <= rd_d;
            cmd_addr  <= addr_d;
            cmd_wdata <= wdata_d;
            err_chk   <= chk_err_d;
            err_cmd   <= cmd_err_d;
            err_tmo   <= tmo_err_d;
            err_cnt   <= err_cnt_d;
        end
    end

    // Next state and next outputs. A byte always beats a coincident timeout.
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        addr_d    = cmd_addr;
        wdata_d   = cmd_wdata;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        chk_err_d = 1'b0;
        cmd_err_d = 1'b0;
        tmo_err_d = 1'b0;

        if (rd_data_valid) begin
            case (state_q)
                IDLE: begin
                    if (rd_data == SOF) begin
                        state_d = S_CMD;
                    end
                end
                S_CMD: begin
                    frame_d.cmd = rd_data;
                    state_d     = S_ADDR;
                end
                S_ADDR: begin
                    frame_d.addr = rd_data;
                    state_d      = S_DATA;
                end
                S_DATA: begin
                    frame_d.data = rd_data;
                    state_d      = S_CHK;
                end
                S_CHK: begin
                    state_d = IDLE;
                    // Checksum is judged before the opcode.
                    if (rd_data != (frame_q.cmd ^ frame_q.addr ^ frame_q.data)) begin
                        chk_err_d = 1'b1;
                    end else if (frame_q.cmd == CMD_WR) begin
                        wr_d    = 1'b1;
                        addr_d  = frame_q.addr;
                        wdata_d = frame_q.data;
                    end else if (frame_q.cmd == CMD_RD) begin
                        rd_d   = 1'b1;
                        addr_d = frame_q.addr;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if ((state_q != IDLE) && tmr_expired) begin
            state_d   = IDLE;
            tmo_err_d = 1'b1;
        end

        if ((chk_err_d || cmd_err_d || tmo_err_d) && (err_cnt != 8'hFF)) begin
            err_cnt_d = err_cnt + 8'd1;
        end else begin
            err_cnt_d = err_cnt;
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: constant vector table, directed
// corner sequences, and randomized traffic against a queue-based frame model.
module tb_uart_cmd_parser;

    localparam int unsigned CLK_PER = 1000;
    localparam int unsigned BAUD    = 100;
    localparam int unsigned GAP     = 2;
    localparam int unsigned LIMIT   = GAP * 10 * (CLK_PER / BAUD); // 200 clocks

    localparam int K_NONE = 0;
    localparam int K_WR   = 1;
    localparam int K_RD   = 2;
    localparam int K_CHK  = 3;
    localparam int K_CMD  = 4;
    localparam int K_TMO  = 5;
    localparam int K_MULT = 99;

    logic       clk_i;
    logic       rst_n;
    logic [7:0] rd_data;
    logic       rd_data_valid;
    logic       cmd_wr, cmd_rd, err_chk, err_cmd, err_tmo;
    logic [7:0] cmd_addr, cmd_wdata, err_cnt;

    uart_cmd_parser #(
        .CLK_PER   (CLK_PER),
        .BAND_RATE (BAUD),
        .GAP_BYTES (GAP)
    ) dut (
        .clk_i         (clk_i),
        .rst_n         (rst_n),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .cmd_wr        (cmd_wr),
        .cmd_rd        (cmd_rd),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .err_chk       (err_chk),
        .err_cmd       (err_cmd),
        .err_tmo       (err_tmo),
        .err_cnt       (err_cnt)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int strobe_count();
        return int'(cmd_wr) + int'(cmd_rd) + int'(err_chk) + int'(err_cmd) + int'(err_tmo);
    endfunction

    function automatic int dut_kind();
        if (strobe_count() > 1) return K_MULT;
        if (cmd_wr)  return K_WR;
        if (cmd_rd)  return K_RD;
        if (err_chk) return K_CHK;
        if (err_cmd) return K_CMD;
        if (err_tmo) return K_TMO;
        return K_NONE;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int         kind;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         cnt;
    } ev_t;

    logic [7:0] fbuf[$];
    ev_t        exp_q[$];
    logic [7:0] m_addr, m_wdata;
    int         m_cnt;
    int         gap;
    bit         mdl_en;

    task automatic model_event(input int kind);
        ev_t e;
        if (kind != K_WR && kind != K_RD && m_cnt < 255) m_cnt++;
        e.kind = kind; e.addr = m_addr; e.wdata = m_wdata; e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [7:0] c, a, d, k;
        if (fbuf.size() == 0 && b != 8'hA5) return;
        fbuf.push_back(b);
        if (fbuf.size() == 5) begin
            c = fbuf[1]; a = fbuf[2]; d = fbuf[3]; k = fbuf[4];
            fbuf.delete();
            if (k != (c ^ a ^ d))  model_event(K_CHK);
            else if (c == 8'h01) begin m_addr = a; m_wdata = d; model_event(K_WR); end
            else if (c == 8'h02) begin m_addr = a; model_event(K_RD); end
            else                   model_event(K_CMD);
        end
    endtask

    // Scoreboard: every strobe must match the oldest predicted event.
    always @(negedge clk_i) begin
        int  k;
        ev_t e;
        if (rst_n && strobe_count() != 0) begin
            check("one_strobe", 32'(strobe_count()), 32'd1);
            if (mdl_en) begin
                k = dut_kind();
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 32'(k), 32'(K_NONE));
                end else begin
                    e = exp_q.pop_front();
                    check("ev_kind", 32'(k), 32'(e.kind));
                    check("ev_addr", 32'(cmd_addr), 32'(e.addr));
                    check("ev_wdata", 32'(cmd_wdata), 32'(e.wdata));
                    check("ev_errcnt", 32'(err_cnt), 32'(e.cnt));
                end
            end
        end
    end

    // ---------------- drivers (phase: 1 time unit after posedge) ----------------
    task automatic send_byte(input logic [7:0] b);
        rd_data       = b;
        rd_data_valid = 1'b1;
        if (mdl_en) model_byte(b);
        gap = 0;
        @(posedge clk_i); #1;
        rd_data_valid = 1'b0;
        rd_data       = 8'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #1;
            gap++;
            if (mdl_en && gap == int'(LIMIT) + 1 && fbuf.size() != 0) begin
                fbuf.delete();
                model_event(K_TMO);
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                              input logic [7:0] d, input logic [7:0] k);
        send_byte(8'hA5); send_byte(c); send_byte(a); send_byte(d); send_byte(k);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        rd_data_valid = 1'b0;
        fbuf.delete();
        exp_q.delete();
        m_addr = 8'h00; m_wdata = 8'h00; m_cnt = 0; gap = 0;
        @(negedge clk_i);
        check("rst_outputs",
              32'({cmd_wr, cmd_rd, err_chk, err_cmd, err_tmo, cmd_addr, cmd_wdata, err_cnt}), 32'd0);
        @(posedge clk_i); #1;
        rst_n = 1'b1;
    endtask

    task automatic check_drained(input string name);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          len;
        logic [63:0] seq;   // first byte in bits [63:56]
        int          kind;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  cnt;
    } vec_t;

    function automatic vec_t mk(input int len, input logic [63:0] seq, input int kind,
                                input logic [7:0] a, input logic [7:0] w, input logic [7:0] c);
        vec_t v;
        v.len = len; v.seq = seq; v.kind = kind; v.addr = a; v.wdata = w; v.cnt = c;
        return v;
    endfunction

    vec_t tbl[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c, a, d, k;
        int         r;

        rd_data = 8'h00; rd_data_valid = 1'b0; rst_n = 1'b0; mdl_en = 1'b0; gap = 0;

        tbl[0] = mk(5, 64'hA5_01_10_3C_2D_00_00_00, K_WR,  8'h10, 8'h3C, 8'd0);
        tbl[1] = mk(5, 64'hA5_02_22_00_20_00_00_00, K_RD,  8'h22, 8'h3C, 8'd0);
        tbl[2] = mk(5, 64'hA5_01_10_3C_00_00_00_00, K_CHK, 8'h22, 8'h3C, 8'd1);
        tbl[3] = mk(5, 64'hA5_07_00_00_07_00_00_00, K_CMD, 8'h22, 8'h3C, 8'd2);
        tbl[4] = mk(8, 64'h00_FF_12_A5_01_AA_55_FE, K_WR,  8'hAA, 8'h55, 8'd2);
        tbl[5] = mk(5, 64'hA5_A5_A5_A5_A5_00_00_00, K_CMD, 8'hAA, 8'h55, 8'd3);
        tbl[6] = mk(5, 64'hA5_02_A5_00_A7_00_00_00, K_RD,  8'hA5, 8'h55, 8'd3);
        tbl[7] = mk(5, 64'hA5_01_7F_80_FE_00_00_00, K_WR,  8'h7F, 8'h80, 8'd3);
        tbl[8] = mk(5, 64'hA5_07_00_00_00_00_00_00, K_CHK, 8'h7F, 8'h80, 8'd4);

        do_reset();

        // Table: strobe exactly one cycle after the CHK byte, then silence.
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < tbl[i].len; j++) begin
                logic [63:0] s;
                s = tbl[i].seq;
                send_byte(s[63 - 8*j -: 8]);
            end
            @(negedge clk_i);
            check($sformatf("tbl%0d_kind", i), 32'(dut_kind()), 32'(tbl[i].kind));
            check($sformatf("tbl%0d_addr", i), 32'(cmd_addr), 32'(tbl[i].addr));
            check($sformatf("tbl%0d_wdata", i), 32'(cmd_wdata), 32'(tbl[i].wdata));
            check($sformatf("tbl%0d_errcnt", i), 32'(err_cnt), 32'(tbl[i].cnt));
            @(posedge clk_i); #1;
            @(negedge clk_i);
            check($sformatf("tbl%0d_single", i), 32'(dut_kind()), 32'(K_NONE));
            @(posedge clk_i); #1;
            idle(2);
        end

        // Directed sequences, scored by the model.
        do_reset();
        mdl_en = 1'b1;

        // Timeout after a partial frame, then a clean frame.
        send_byte(8'hA5); send_byte(8'h01);
        idle(int'(LIMIT) + 20);
        check_drained("tmo_seen");
        check("tmo_errcnt", 32'(err_cnt), 32'd1);
        send_frame(8'h01, 8'h10, 8'h3C, 8'h2D);
        idle(3);
        check_drained("after_tmo_frame");
        check("after_tmo_addr", 32'(cmd_addr), 32'h10);

        // Byte arriving on the limit cycle wins over the timeout.
        send_byte(8'hA5); send_byte(8'h02);
        idle(int'(LIMIT));
        send_byte(8'h33); send_byte(8'h00); send_byte(8'h31);
        idle(3);
        check_drained("limit_byte_wins");
        check("limit_errcnt", 32'(err_cnt), 32'd1);
        check("limit_addr", 32'(cmd_addr), 32'h33);

        // Back-to-back frames, zero idle gap.
        send_frame(8'h01, 8'h01, 8'h02, 8'h02);
        send_frame(8'h02, 8'h04, 8'h00, 8'h06);
        idle(3);
        check_drained("back_to_back");

        // Error counter saturation.
        for (int i = 0; i < 256; i++) send_frame(8'h01, 8'h00, 8'h00, 8'h00);
        idle(3);
        check_drained("sat_events");
        check("sat_errcnt", 32'(err_cnt), 32'd255);

        // Reset mid-frame discards the partial frame.
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
        do_reset();
        send_byte(8'h3C); send_byte(8'h2D);
        idle(2);
        check("rst_no_strobe", 32'(exp_q.size()), 32'd0);
        send_frame(8'h01, 8'h10, 8'h3C, 8'h2D);
        idle(3);
        check_drained("rst_then_frame");
        check("rst_frame_wdata", 32'(cmd_wdata), 32'h3C);

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2) begin
                for (int g = 0; g < int'($urandom_range(1, 3)); g++) send_byte(8'($urandom));
            end else begin
                r = int'($urandom_range(0, 3));
                c = (r == 0) ? 8'($urandom) : ((r == 1) ? 8'h02 : 8'h01);
                a = 8'($urandom);
                d = 8'($urandom);
                k = c ^ a ^ d;
                if ($urandom_range(0, 4) == 0) k = k ^ 8'($urandom_range(1, 255));
                send_byte(8'hA5);
                for (int i = 0; i < 4; i++) begin
                    logic [31:0] w;
                    w = {c, a, d, k};
                    if ($urandom_range(0, 19) == 0) idle(int'(LIMIT) + int'($urandom_range(0, 2)) - 1);
                    else idle(int'($urandom_range(0, 1)));
                    send_byte(w[31 - 8*i -: 8]);
                end
            end
            idle(int'($urandom_range(0, 3)));
        end
        idle(int'(LIMIT) + 10);
        check_drained("random_drained");
        check("random_errcnt", 32'(err_cnt), 32'(m_cnt));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
